sonic_rx_wr_sched: RTL

- Write-side scheduler for the SoNIC Rx circular buffer. Runs in the wr_clock (SFP/PCS) domain.
- Sequences buffer reset and arming from enable_sfp, and gates 40-bit PCS beats into the buffer write port.
- Handles backpressure from buffer full by dropping and counting beats.
- Maintains the write pointer and emits a per-block completion pulse that downstream Rx IRQ logic consumes.

---
 rtl/sonic_rx_wr_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sonic_rx_wr_sched.sv
// SoNIC Rx circular-buffer write scheduler (wr_clock domain): arms the buffer, gates PCS beats, counts drops.
// Optional idle-beat filtering is compiled in with `define SONIC_RX_IDLE_FILTER_EN.
module sonic_rx_wr_sched #(
  parameter int DATA_WIDTH       = 40,
  parameter int PTR_WIDTH        = 16,
  parameter int BLOCK_WORDS_LOG2 = 6,
  parameter int ARM_CYCLES       = 4,
  parameter int DROP_CNT_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '0
) (
  input  logic                      wr_clock,
  input  logic                      reset,
  input  logic                      enable_sfp,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      buf_full,
  input  logic                      buf_almost_full,
  output logic                      buf_wrreq,
  output logic [DATA_WIDTH-1:0]     buf_data,
  output logic                      buf_reset,
  output logic [PTR_WIDTH-1:0]      wr_ptr,
  output logic                      block_done,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic [2:0]                sched_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STALL = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

`ifdef SONIC_RX_IDLE_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic                      sync1_reg;
  logic                      en_s_reg;
  logic [2:0]                state_reg, state_next;
  logic [3:0]                arm_cnt_reg;
  logic                      buf_wrreq_reg;
  logic [DATA_WIDTH-1:0]     buf_data_reg;
  logic                      buf_reset_reg;
  logic [PTR_WIDTH-1:0]      wr_ptr_reg;
  logic [PTR_WIDTH-1:0]      wr_ptr_inc;
  logic                      block_done_reg;
  logic [DROP_CNT_WIDTH-1:0] drop_count_reg;
  logic                      is_idle;
  logic                      accept;
  logic                      drop;

  // enable_sfp comes from the register domain; two flops before use.
  always_ff @(posedge wr_clock or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      en_s_reg  <= 1'b0;
    end else begin
      sync1_reg <= enable_sfp;
      en_s_reg  <= sync1_reg;
    end
  end

  assign is_idle    = FILTER_EN && (in_data == IDLE_PATTERN);
  assign wr_ptr_inc = wr_ptr_reg + PTR_WIDTH'(1);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (en_s_reg) state_next = S_ARM;
      end
      S_ARM: begin
        if (!en_s_reg)              state_next = S_DRAIN;
        else if (arm_cnt_reg == 4'd1) state_next = S_RUN;
      end
      S_RUN: begin
        if (!en_s_reg) begin
          state_next = S_DRAIN;
        end else if (in_valid && !is_idle) begin
          if (buf_full) begin
            drop       = 1'b1;
            state_next = S_STALL;
          end else begin
            accept = 1'b1;
          end
        end
      end
      S_STALL: begin
        if (!en_s_reg) begin
          state_next = S_DRAIN;
        end else begin
          // The beat seen in the cycle that leaves STALL is still dropped.
          drop = in_valid;
          if (!buf_full && !buf_almost_full) state_next = S_RUN;
        end
      end
      S_DRAIN: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wr_clock or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      arm_cnt_reg    <= 4'd0;
      buf_wrreq_reg  <= 1'b0;
      buf_data_reg   <= '0;
      buf_reset_reg  <= 1'b1;
      wr_ptr_reg     <= '0;
      block_done_reg <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      buf_reset_reg <= (state_next == S_IDLE);

      if (state_reg == S_IDLE)     arm_cnt_reg <= 4'(ARM_CYCLES);
      else if (state_reg == S_ARM) arm_cnt_reg <= arm_cnt_reg - 4'd1;

      buf_wrreq_reg  <= accept;
      block_done_reg <= accept && (wr_ptr_inc[BLOCK_WORDS_LOG2-1:0] == '0);
      if (accept) begin
        buf_data_reg <= in_data;
        wr_ptr_reg   <= wr_ptr_inc;
      end else if (state_reg == S_IDLE || state_reg == S_DRAIN) begin
        wr_ptr_reg <= '0;
      end

      // Drop count survives DRAIN/IDLE and only clears on re-arming.
      if (state_reg == S_IDLE && state_next == S_ARM)
        drop_count_reg <= '0;
      else if (drop && drop_count_reg != '1)
        drop_count_reg <= drop_count_reg + DROP_CNT_WIDTH'(1);
    end
  end

  assign buf_wrreq   = buf_wrreq_reg;
  assign buf_data    = buf_data_reg;
  assign buf_reset   = buf_reset_reg;
  assign wr_ptr      = wr_ptr_reg;
  assign block_done  = block_done_reg;
  assign drop_count  = drop_count_reg;
  assign sched_state = state_reg;

endmodule
